// File: rtl/core_mem_pkg.sv
// Shared types and widths for the core memory arbiter and its optional fetch buffer.
package core_mem_pkg;

    typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;

    localparam int LAT_CNT_W   = 4;
    localparam int WORD_ADDR_W = 30;

endpackage

// File: rtl/core_fetch_buf.sv
// One-entry fetch buffer: remembers the last fetched word so a repeat fetch completes without the memory.
module core_fetch_buf
    import core_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_lookup,
    input  logic [WORD_ADDR_W-1:0] i_lookup_addr,
    input  logic                   i_fill,
    input  logic [WORD_ADDR_W-1:0] i_fill_addr,
    input  logic [31:0]            i_fill_data,
    input  logic                   i_inval,
    input  logic [WORD_ADDR_W-1:0] i_inval_addr,
    output logic                   o_hit,
    output logic [31:0]            o_data
);

    logic                   r_valid;
    logic [WORD_ADDR_W-1:0] r_tag;
    logic [31:0]            r_data;

    assign o_hit  = i_lookup & r_valid & (r_tag == i_lookup_addr);
    assign o_data = r_data;

    // Fill and invalidate never coincide: fills happen at the end of a fetch access, invalidates at a data grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_addr;
            r_data  <= i_fill_data;
        end else if (i_inval && r_valid && (r_tag == i_inval_addr)) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one fixed-latency single-port memory.
// Define FETCH_BUF_EN to add a one-entry fetch buffer that can answer repeat fetches without a memory access.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT   = LAT_CNT_W'(MEM_LAT - 1);
    localparam logic [LAT_CNT_W-1:0] STARVE_LIM = LAT_CNT_W'(STARVE_MAX);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    arb_owner_t             r_owner;
    arb_owner_t             w_owner_next;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic [LAT_CNT_W-1:0]   w_cnt_next;
    logic [LAT_CNT_W-1:0]   r_starve;
    logic [LAT_CNT_W-1:0]   w_starve_next;
    logic                   r_we;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic                   r_if_ready;
    logic                   r_d_ready;
    logic [31:0]            r_if_rdata;
    logic [31:0]            r_d_rdata;

    logic                   w_fetch_busy;
    logic                   w_if_elig;
    logic                   w_d_elig;
    logic                   w_if_hit;
    logic                   w_if_arb;
    logic [31:0]            w_buf_data;
    logic                   w_grant_d;
    logic                   w_grant_f;
    logic                   w_last;
    logic                   w_fetch_done;
    logic                   w_data_done;

    // A port's request is ignored in its own ready cycle: the requester only updates at that edge.
    assign w_fetch_busy = (r_state == ARB_ACCESS) && (r_owner == OWN_FETCH);
    assign w_if_elig    = if_req & ~r_if_ready & ~w_fetch_busy;
    assign w_d_elig     = d_req & ~r_d_ready;
    assign w_if_arb     = w_if_elig & ~w_if_hit;

`ifdef FETCH_BUF_EN
    core_fetch_buf u_fetch_buf (
        .clk           (clk),
        .reset         (reset),
        .i_lookup      (w_if_elig),
        .i_lookup_addr (if_addr[31:2]),
        .i_fill        (w_fetch_done),
        .i_fill_addr   (r_addr[31:2]),
        .i_fill_data   (mem_rdata),
        .i_inval       (w_grant_d & d_we),
        .i_inval_addr  (d_addr[31:2]),
        .o_hit         (w_if_hit),
        .o_data        (w_buf_data)
    );
`else
    assign w_if_hit   = 1'b0;
    assign w_buf_data = '0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_cnt_next    = r_cnt;
        w_starve_next = r_starve;
        w_grant_d     = 1'b0;
        w_grant_f     = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // Data normally wins (older instruction) unless a waiting fetch has been passed over too often.
                if (w_d_elig && !(w_if_arb && (r_starve == STARVE_LIM))) begin
                    w_grant_d     = 1'b1;
                    w_state_next  = ARB_ACCESS;
                    w_owner_next  = OWN_DATA;
                    w_cnt_next    = LAT_INIT;
                    w_starve_next = w_if_arb ? (r_starve + 1'b1) : '0;
                end else if (w_if_arb) begin
                    w_grant_f     = 1'b1;
                    w_state_next  = ARB_ACCESS;
                    w_owner_next  = OWN_FETCH;
                    w_cnt_next    = LAT_INIT;
                    w_starve_next = '0;
                end
            end
            ARB_ACCESS: begin
                if (r_cnt == '0) begin
                    w_last       = 1'b1;
                    w_state_next = ARB_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    assign w_fetch_done = w_last & (r_owner == OWN_FETCH);
    assign w_data_done  = w_last & (r_owner == OWN_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_owner    <= OWN_FETCH;
            r_cnt      <= '0;
            r_starve   <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_cnt    <= w_cnt_next;
            r_starve <= w_starve_next;
            if (w_grant_d) begin
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else if (w_grant_f) begin
                r_we    <= 1'b0;
                r_addr  <= if_addr;
                r_wdata <= '0;
            end
            r_if_ready <= w_fetch_done | w_if_hit;
            r_d_ready  <= w_data_done;
            if (w_fetch_done) begin
                r_if_rdata <= mem_rdata;
            end else if (w_if_hit) begin
                r_if_rdata <= w_buf_data;
            end
            if (w_data_done && !r_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (r_state == ARB_ACCESS);
    assign mem_we    = (r_state == ARB_ACCESS) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_core_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: remaining busy cycles, who owns the memory, what was latched, pending ready pulses.
    int          m_busy;
    bit          m_own_f;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_starve;
    bit          m_if_rdy;
    bit          m_d_rdy;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    bit          b_valid;
    logic [29:0] b_tag;
    logic [31:0] b_data;

    core_mem_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_own_f = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_starve = 0;
        m_if_rdy = 0; m_d_rdy = 0; m_if_rdata = '0; m_d_rdata = '0;
        b_valid = 0; b_tag = '0; b_data = '0;
    endtask

    task automatic grant(input bit fetch, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        m_busy = MEM_LAT; m_own_f = fetch; m_we = we; m_addr = addr; m_wdata = wdata;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit nx_if, nx_d, f_ok, f_arb, d_ok, hit;
        if (reset) begin
            model_clear();
            return;
        end
        nx_if = 0; nx_d = 0; hit = 0;
        f_ok = if_req && !m_if_rdy && !(m_busy > 0 && m_own_f);
`ifdef FETCH_BUF_EN
        hit = f_ok && b_valid && (b_tag == if_addr[31:2]);
        if (hit) begin
            nx_if = 1; m_if_rdata = b_data;
        end
`endif
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (m_own_f) begin
                    m_if_rdata = mem_rdata; nx_if = 1;
                    b_valid = 1; b_tag = m_addr[31:2]; b_data = mem_rdata;
                end else begin
                    if (!m_we) m_d_rdata = mem_rdata;
                    nx_d = 1;
                end
            end
        end else begin
            f_arb = f_ok && !hit;
            d_ok  = d_req && !m_d_rdy;
            if (d_ok && !(f_arb && m_starve == STARVE_MAX)) begin
                grant(0, d_we, d_addr, d_wdata);
                m_starve = f_arb ? m_starve + 1 : 0;
                if (d_we && b_valid && b_tag == d_addr[31:2]) b_valid = 0;
            end else if (f_arb) begin
                grant(1, 0, if_addr, '0);
                m_starve = 0;
            end
        end
        m_if_rdy = nx_if;
        m_d_rdy  = nx_d;
    endtask

    task automatic check_outputs();
        check("if_ready", 32'(if_ready), 32'(m_if_rdy));
        check("d_ready", 32'(d_ready), 32'(m_d_rdy));
        check("if_rdata", if_rdata, m_if_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        check("mem_en", 32'(mem_en), 32'(m_busy > 0));
        check("mem_we", 32'(mem_we), 32'(m_busy > 0 && m_we));
        if (m_busy > 0) check("mem_addr", mem_addr, m_addr);
        if (m_busy > 0 && m_we) check("mem_wdata", mem_wdata, m_wdata);
        if (m_if_rdy) $display("[%0t] fetch done rdata=%h", $time, m_if_rdata);
        if (m_d_rdy) $display("[%0t] data done rdata=%h", $time, m_d_rdata);
    endtask

    task automatic tick();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit fetch, input int start, input int exp, input string tag);
        int n = start;
        while (!(fetch ? if_ready : d_ready) && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h200, 32'h204};
    logic [31:0] saved;

    initial begin
        reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        model_clear();
        @(posedge clk); #1;
        tick();
        reset = 0;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        tick();

        // Single fetch with fixed latency.
        if_req = 1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        tick();
        check("t1_mem_en", 32'(mem_en), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h100);
        wait_ready(1, 1, MEM_LAT + 1, "t1_latency");
        check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 0;
        tick();

        // Simultaneous requests: data first, fetch granted in the data ready cycle.
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; mem_rdata = 32'h0BADF00D;
        wait_ready(0, 0, MEM_LAT + 1, "t2_data_lat");
        d_req = 0;
        wait_ready(1, 0, MEM_LAT + 1, "t2_fetch_lat");
        if_req = 0;
        tick();

        // Starvation limit: fetch is withheld in data ready cycles so contention recurs each grant.
        d_we = 0; d_addr = 32'h300; if_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            if_req = 1; d_req = 1; mem_rdata = $urandom;
            tick();
            check($sformatf("t3_grant%0d", k), mem_addr, (k == 4) ? 32'h400 : 32'h300);
            repeat (MEM_LAT) tick();
            if_req = 0; d_req = 0;
            tick();
        end

        // Write leaves d_rdata alone.
        saved = m_d_rdata;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
        for (int c = 0; c < MEM_LAT; c++) begin
            tick();
            check("t4_mem_we", 32'(mem_we), 32'd1);
            check("t4_mem_wdata", mem_wdata, 32'h12345678);
        end
        tick();
        check("t4_d_ready", 32'(d_ready), 32'd1);
        check("t4_d_rdata", d_rdata, saved);
        d_req = 0; d_we = 0;
        tick();

        // Reset in the middle of a fetch access.
        if_req = 1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        tick();
        reset = 1;
        tick();
        reset = 0; if_req = 0;
        check("t5_mem_en", 32'(mem_en), 32'd0);
        check("t5_if_rdata", if_rdata, 32'd0);
        repeat (4) tick();
        if_req = 1;
        wait_ready(1, 0, MEM_LAT + 1, "t5_latency");
        check("t5_if_rdata2", if_rdata, 32'hDEADBEEF);
        if_req = 0;
        tick();

`ifdef FETCH_BUF_EN
        reset = 1; tick(); reset = 0; tick();
        if_req = 1; if_addr = 32'h100; mem_rdata = 32'hCAFE0001;
        wait_ready(1, 0, MEM_LAT + 1, "t6_miss1");
        if_req = 0; tick();
        if_req = 1; mem_rdata = 32'h0;
        wait_ready(1, 0, 1, "t6_hit");
        check("t6_hit_mem_en", 32'(mem_en), 32'd0);
        check("t6_hit_data", if_rdata, 32'hCAFE0001);
        if_req = 0; tick();
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h55;
        wait_ready(0, 0, MEM_LAT + 1, "t6_write");
        d_req = 0; d_we = 0; tick();
        if_req = 1; mem_rdata = 32'hCAFE0002;
        wait_ready(1, 0, MEM_LAT + 1, "t6_miss2");
        check("t6_miss2_data", if_rdata, 32'hCAFE0002);
        if_req = 0; tick();
`endif

        // Random traffic from both ports against the model.
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 249) == 0);
            if (m_if_rdy || !if_req) begin
                if_req  = ($urandom_range(0, 2) == 0);
                if_addr = pool[$urandom_range(0, 3)];
            end
            if (m_d_rdy || !d_req) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = pool[$urandom_range(0, 3)];
                d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            tick();
        end
        reset = 0; if_req = 0; d_req = 0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
